// File: rtl/drbg_keystream_buffer.sv
// Prefetches 256-bit Hash-DRBG words into a small word FIFO and serves them
// MSB-first as OUT_WIDTH-bit key chunks to the scrambler key logic.
//
// state    | meaning
// F_IDLE   | no fetch outstanding; launch when a slot is free and the DRBG is ready
// F_REQ    | drbg_next held high until the DRBG shows busy without next_ready
// F_WAIT   | request accepted; waiting for next_ready to capture the word
// F_SETTLE | word captured; waiting for the DRBG to drop busy
module drbg_keystream_buffer #(
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  output logic                               drbg_next_o,
  input  logic                               drbg_next_ready_i,
  input  logic                               drbg_init_ready_i,
  input  logic                               drbg_busy_i,
  input  logic                               drbg_do_reseed_i,
  input  logic [255:0]                       drbg_random_bits_i,
  input  logic                               key_req_i,
  output logic                               key_valid_o,
  output logic [OUT_WIDTH-1:0]               key_data_o,
  input  logic                               flush_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    words_available_o,
  output logic                               underflow_o,
  output logic                               reseed_pending_o
);

  localparam int NCHUNK = 256 / OUT_WIDTH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    F_IDLE   = 2'd0,
    F_REQ    = 2'd1,
    F_WAIT   = 2'd2,
    F_SETTLE = 2'd3
  } fetch_state_e;

  fetch_state_e  state_q, state_d;
  logic          inflight_q, inflight_d;
  logic          discard_q, discard_d;
  logic [255:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [KW-1:0] k_q, k_d;
  logic          underflow_q, underflow_d;
  logic          reseed_q;

  logic          launch_ok;
  logic          capture;
  logic          push;
  logic          fire;
  logic          pop;
  logic          key_valid;
  logic [255:0]  head_shifted;

  // Occupancy includes the outstanding fetch so a returning word always has a slot.
  assign launch_ok = ((32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH) &&
                     drbg_init_ready_i && !drbg_busy_i && !drbg_do_reseed_i && !flush_i;

  always_comb begin
    state_d     = state_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q | (flush_i & inflight_q);
    capture     = 1'b0;
    drbg_next_o = 1'b0;
    case (state_q)
      F_IDLE: begin
        discard_d = 1'b0;
        if (launch_ok) begin
          state_d    = F_REQ;
          inflight_d = 1'b1;
        end
      end
      F_REQ: begin
        drbg_next_o = 1'b1;
        if (!drbg_init_ready_i) begin
          state_d    = F_IDLE;
          inflight_d = 1'b0;
        end else if (drbg_busy_i && !drbg_next_ready_i) begin
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (!drbg_init_ready_i) begin
          state_d    = F_IDLE;
          inflight_d = 1'b0;
        end else if (drbg_next_ready_i) begin
          capture    = 1'b1;
          state_d    = F_SETTLE;
          inflight_d = 1'b0;
        end
      end
      F_SETTLE: begin
        if (!drbg_init_ready_i || !drbg_busy_i) begin
          state_d = F_IDLE;
        end
      end
      default: begin
        state_d    = F_IDLE;
        inflight_d = 1'b0;
      end
    endcase
  end

  // A discarded (flushed) fetch still completes its handshake but never lands.
  assign push      = capture && !discard_q && !flush_i;
  assign key_valid = (count_q != '0);
  assign fire      = key_req_i && key_valid;
  assign pop       = fire && (k_q == K_LAST);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    k_d         = k_q;
    underflow_d = underflow_q | (key_req_i & ~key_valid);
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      k_d         = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == P_LAST) ? '0 : rd_ptr_q + 1'b1;
        k_d      = '0;
      end else if (fire) begin
        k_d = k_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    head_shifted = fifo_q[rd_ptr_q] << (32'(k_q) * OUT_WIDTH);
    key_data_o   = key_valid ? head_shifted[255 -: OUT_WIDTH] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= F_IDLE;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      k_q         <= '0;
      underflow_q <= 1'b0;
      reseed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      k_q         <= k_d;
      underflow_q <= underflow_d;
      reseed_q    <= drbg_do_reseed_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= drbg_random_bits_i;
    end
  end

  assign key_valid_o       = key_valid;
  assign words_available_o = count_q;
  assign underflow_o       = underflow_q;
  assign reseed_pending_o  = reseed_q;

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// Directed bench: a 16-bit/depth-2 buffer and a 64-bit/depth-1 buffer, each
// fed by a small behavioural Hash-DRBG model.
module tb_drbg_keystream_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // instance A: OUT_WIDTH=16, FIFO_DEPTH=2
  logic        a_next, a_req, a_valid, a_flush, a_under, a_rpend;
  logic [15:0] a_data;
  logic [1:0]  a_words;
  logic        m_init, m_busy, m_nr, m_reseed;
  logic [255:0] m_bits;
  int          m_ph, m_cnt, m_idx;
  logic        cfg_init;
  int          cfg_reseed_at;

  // instance B: OUT_WIDTH=64, FIFO_DEPTH=1
  logic        b_next, b_req, b_valid, b_flush, b_under, b_rpend;
  logic [63:0] b_data;
  logic [0:0]  b_words;
  logic        n_init, n_busy, n_nr;
  logic [255:0] n_bits;
  int          n_ph, n_cnt, n_idx;
  logic        cfg1_init;

  logic [15:0] tbl_a [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

  function automatic logic [255:0] w(input int n);
    logic [15:0] x;
    x = 16'(n) * 16'h1111;
    return {4{64'h0123456789ABCDEF}} ^ {16{x}};
  endfunction

  drbg_keystream_buffer #(.OUT_WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .reset_i(rst), .drbg_next_o(a_next),
    .drbg_next_ready_i(m_nr), .drbg_init_ready_i(m_init), .drbg_busy_i(m_busy),
    .drbg_do_reseed_i(m_reseed), .drbg_random_bits_i(m_bits),
    .key_req_i(a_req), .key_valid_o(a_valid), .key_data_o(a_data), .flush_i(a_flush),
    .words_available_o(a_words), .underflow_o(a_under), .reseed_pending_o(a_rpend)
  );

  drbg_keystream_buffer #(.OUT_WIDTH(64), .FIFO_DEPTH(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .drbg_next_o(b_next),
    .drbg_next_ready_i(n_nr), .drbg_init_ready_i(n_init), .drbg_busy_i(n_busy),
    .drbg_do_reseed_i(1'b0), .drbg_random_bits_i(n_bits),
    .key_req_i(b_req), .key_valid_o(b_valid), .key_data_o(b_data), .flush_i(b_flush),
    .words_available_o(b_words), .underflow_o(b_under), .reseed_pending_o(b_rpend)
  );

  // DRBG model A: 0=uninit, 1=idle, 2=generating, 3=next_ready, 4=finishing
  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b0; m_busy <= 1'b1; m_nr <= 1'b0; m_reseed <= 1'b0;
      m_bits <= '0; m_ph <= 0; m_cnt <= 0; m_idx <= 0;
    end else begin
      case (m_ph)
        0: if (cfg_init) begin m_init <= 1'b1; m_busy <= 1'b0; m_reseed <= 1'b0; m_ph <= 1; end
        1: if (a_next) begin m_busy <= 1'b1; m_cnt <= 2; m_ph <= 2; end
        2: if (m_cnt == 0) begin
             m_nr <= 1'b1; m_bits <= w(m_idx); m_idx <= m_idx + 1; m_ph <= 3;
           end else m_cnt <= m_cnt - 1;
        3: begin m_nr <= 1'b0; m_ph <= 4; end
        default:
          if (m_idx == cfg_reseed_at) begin
            m_init <= 1'b0; m_reseed <= 1'b1; m_ph <= 0;
          end else begin
            m_busy <= 1'b0; m_ph <= 1;
          end
      endcase
    end
  end

  // DRBG model B: same shape, shorter latency, no reseed
  always @(posedge clk) begin
    if (rst) begin
      n_init <= 1'b0; n_busy <= 1'b1; n_nr <= 1'b0;
      n_bits <= '0; n_ph <= 0; n_cnt <= 0; n_idx <= 0;
    end else begin
      case (n_ph)
        0: if (cfg1_init) begin n_init <= 1'b1; n_busy <= 1'b0; n_ph <= 1; end
        1: if (b_next) begin n_busy <= 1'b1; n_cnt <= 1; n_ph <= 2; end
        2: if (n_cnt == 0) begin
             n_nr <= 1'b1; n_bits <= w(n_idx); n_idx <= n_idx + 1; n_ph <= 3;
           end else n_cnt <= n_cnt - 1;
        3: begin n_nr <= 1'b0; n_ph <= 4; end
        default: begin n_busy <= 1'b0; n_ph <= 1; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nexts;
    int got;
    int maxw;
    logic [255:0] tmp;

    rst = 1'b1; cfg_init = 1'b0; cfg1_init = 1'b0; cfg_reseed_at = -1;
    a_req = 1'b0; a_flush = 1'b0; b_req = 1'b0; b_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_next", a_next, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_words", a_words, 0);
    chk("rst_under", a_under, 0);
    chk("rst_rpend", a_rpend, 0);
    rst = 1'b0;
    @(negedge clk);

    // underflow with empty FIFO and DRBG not yet instantiated
    a_req = 1'b1;
    chk("uf_valid", a_valid, 0);
    chk("uf_data", a_data, 0);
    @(negedge clk);
    a_req = 1'b0;
    chk("uf_flag", a_under, 1);
    chk("uf_next", a_next, 0);

    // fill: exactly two fetches
    cfg_init = 1'b1;
    repeat (80) @(negedge clk);
    chk("fill_fetches", m_idx, 2);
    chk("fill_words", a_words, 2);
    chk("fill_next", a_next, 0);
    chk("fill_head", a_data, 16'h0123);
    chk("uf_sticky", a_under, 1);

    // drain word A chunk by chunk; reseed will hit after the third delivery
    cfg_init = 1'b0;
    cfg_reseed_at = 3;
    a_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("chunkA_%0d", i), a_data, tbl_a[i % 4]);
      @(negedge clk);
    end
    a_req = 1'b0;
    chk("pop_words", a_words, 1);
    chk("pop_headB", a_data, 16'h1032);
    @(negedge clk);
    chk("pop_launch", a_next, 1);

    // reseed: third word buffered, then no more requests
    for (int i = 0; i < 100 && !(m_ph == 0 && m_reseed); i++) @(negedge clk);
    chk("rs_parked", (m_ph == 0 && m_reseed), 1);
    chk("rs_words", a_words, 2);
    a_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) chk("rs_B_first", a_data, 16'h1032);
      if (i == 15) chk("rs_B_last", a_data, 16'hDCFE);
      @(negedge clk);
    end
    a_req = 1'b0;
    nexts = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_next) nexts++;
      @(negedge clk);
    end
    chk("rs_no_fetch", nexts, 0);
    chk("rs_words1", a_words, 1);
    chk("rs_pending", a_rpend, 1);
    chk("rs_headC", a_data, 16'h2301);
    chk("rs_under", a_under, 1);
    cfg_init = 1'b1;
    for (int i = 0; i < 100 && a_words != 2; i++) @(negedge clk);
    chk("rs_resume_words", a_words, 2);
    chk("rs_resume_fetches", m_idx, 4);
    chk("rs_pending_clr", a_rpend, 0);
    chk("rs_resume_head", a_data, 16'h2301);

    // flush while the fetch of word 4 is in F_WAIT
    a_req = 1'b1;
    repeat (16) @(negedge clk);
    a_req = 1'b0;
    for (int i = 0; i < 50 && !(m_ph == 2 && m_cnt == 1); i++) @(negedge clk);
    chk("fl_inwait", (m_ph == 2 && m_cnt == 1), 1);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("fl_words", a_words, 0);
    chk("fl_valid", a_valid, 0);
    chk("fl_data", a_data, 0);
    chk("fl_under", a_under, 0);
    nexts = 0;
    for (int i = 0; i < 50 && !(m_ph == 1 && m_idx == 5); i++) begin
      if (a_next) nexts++;
      @(negedge clk);
    end
    chk("fl_done", (m_ph == 1 && m_idx == 5), 1);
    chk("fl_no_req_busy", nexts, 0);
    chk("fl_discarded", a_words, 0);
    for (int i = 0; i < 60 && !a_valid; i++) @(negedge clk);
    chk("fl_next_valid", a_valid, 1);
    chk("fl_next_head", a_data, 16'h5476);
    chk("fl_next_idx", m_idx, 6);

    // depth-1, 64-bit instance: 8 words streamed in delivery order
    cfg1_init = 1'b1;
    b_req = 1'b1;
    got = 0;
    maxw = 0;
    for (int i = 0; i < 2000 && got < 32; i++) begin
      if (int'(b_words) > maxw) maxw = int'(b_words);
      if (b_valid) begin
        tmp = w(got / 4);
        chk($sformatf("seq_w%0d_c%0d", got / 4, got % 4), b_data, tmp[255 - 64 * (got % 4) -: 64]);
        got++;
      end
      @(negedge clk);
    end
    b_req = 1'b0;
    chk("seq_count", got, 32);
    chk("seq_maxw", maxw, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
